// File: rtl/efuse_pkg.sv
// Shared types and default timing for the eFuse sequencer/arbiter slice.
package efuse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    DONE
  } efuse_state_e;

  localparam int T_SETUP_DEF = 2;
  localparam int T_RD_DEF    = 4;
  localparam int T_PGM_DEF   = 16;
  localparam int T_HOLD_DEF  = 1;

  // Wide enough to hold the largest reload value of any timed state.
  function automatic int cnt_width(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

  function automatic int idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/efuse_seq_arb_if.sv
// Client-side request/ack bus shared by all hardware requesters.
interface efuse_seq_arb_if #(
  parameter int NCH = 2,
  parameter int AW  = 8,
  parameter int DW  = 8
);
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    req_wr;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH-1:0]    ack;
  logic [DW-1:0]     rdata;

  modport master (output req, req_wr, req_addr, input ack, rdata);
  modport slave  (input req, req_wr, req_addr, output ack, rdata);
endinterface

// File: rtl/efuse_rr_arb.sv
// Round-robin arbiter; the search starts one past the last granted channel.
module efuse_rr_arb
  import efuse_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = idx_width(NCH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  gnt_idx,
  output logic           gnt_vld
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] ch;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    ch      = '0;
    for (int i = 0; i < NCH; i++) begin
      ch = IW'((int'(ptr) + i) % NCH);
      if (!gnt_vld && req[ch]) begin
        gnt_vld     = 1'b1;
        gnt_idx     = ch;
        gnt[ch]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (gnt_idx == IW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/efuse_seq_arb.sv
// eFuse access front-end: arbitrates requesters and times SETUP/STROBE/HOLD on the macro pins.
//   state  | meaning
//   IDLE   | waiting; register override drives pins when rg_efuse_reg_mode=1
//   SETUP  | aen/addr stable ahead of the strobe (T_SETUP cycles)
//   STROBE | rden or pgmen high (T_RD or T_PGM cycles)
//   HOLD   | aen/addr held after the strobe (T_HOLD cycles)
//   DONE   | one-cycle ack to the granted channel
module efuse_seq_arb
  import efuse_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_RD    = T_RD_DEF,
  parameter int T_PGM   = T_PGM_DEF,
  parameter int T_HOLD  = T_HOLD_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scan_mode,
  input  logic          rg_efuse_reg_mode,
  input  logic          rg_efuse_pgmen,
  input  logic          rg_efuse_rden,
  input  logic          rg_efuse_aen,
  input  logic [AW-1:0] rg_efuse_addr,
  output logic [DW-1:0] rg_efuse_d,
  efuse_seq_arb_if.slave bus,
  output logic          busy,
  output logic          efuse_pgmen_o,
  output logic          efuse_rden_o,
  output logic          efuse_aen_o,
  output logic [AW-1:0] efuse_addr_o,
  input  logic [DW-1:0] efuse_rdata_i
);

  localparam int CW = cnt_width(T_SETUP, T_RD, T_PGM, T_HOLD);
  localparam int IW = idx_width(NCH);

  efuse_state_e   state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic           tc, reg_act, grant_go;
  logic [NCH-1:0] gnt, lat_gnt;
  logic [IW-1:0]  gnt_idx;
  logic           gnt_vld, gnt_wr, lat_wr;
  logic [AW-1:0]  gnt_addr, lat_addr, addr_d, addr_q;
  logic           pgmen_d, rden_d, aen_d, pgmen_q, rden_q, aen_q;
  logic [DW-1:0]  rdata_q, rg_d_q;

  assign tc       = (cnt == '0);
  assign reg_act  = (state == IDLE) && rg_efuse_reg_mode;
  assign grant_go = (state == IDLE) && gnt_vld && !rg_efuse_reg_mode && !scan_mode;

  efuse_rr_arb #(.NCH(NCH), .IW(IW)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req),
    .advance (grant_go),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    gnt_addr = '0;
    gnt_wr   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (gnt_idx == IW'(i)) begin
        gnt_addr = bus.req_addr[i*AW +: AW];
        gnt_wr   = bus.req_wr[i];
      end
    end
  end

  // Each timed state reloads the down-counter on entry and leaves at terminal count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt - 1'b1;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (grant_go) begin
          state_nxt = SETUP;
          cnt_nxt   = CW'(T_SETUP - 1);
        end
      end
      SETUP: if (tc) begin
        state_nxt = STROBE;
        cnt_nxt   = lat_wr ? CW'(T_PGM - 1) : CW'(T_RD - 1);
      end
      STROBE: if (tc) begin
        state_nxt = HOLD;
        cnt_nxt   = CW'(T_HOLD - 1);
      end
      HOLD: if (tc) begin
        state_nxt = DONE;
        cnt_nxt   = '0;
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Pins are decoded from the next state so they switch on the same edge as the FSM.
  always_comb begin
    pgmen_d = 1'b0;
    rden_d  = 1'b0;
    aen_d   = 1'b0;
    addr_d  = '0;
    case (state_nxt)
      SETUP, HOLD: begin
        aen_d  = 1'b1;
        addr_d = (state == IDLE) ? gnt_addr : lat_addr;
      end
      STROBE: begin
        aen_d   = 1'b1;
        addr_d  = lat_addr;
        rden_d  = !lat_wr;
        pgmen_d = lat_wr;
      end
      IDLE: if (reg_act) begin
        pgmen_d = rg_efuse_pgmen;
        rden_d  = rg_efuse_rden;
        aen_d   = rg_efuse_aen;
        addr_d  = rg_efuse_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_gnt  <= '0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      pgmen_q  <= 1'b0;
      rden_q   <= 1'b0;
      aen_q    <= 1'b0;
      addr_q   <= '0;
      rdata_q  <= '0;
      rg_d_q   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pgmen_q <= pgmen_d;
      rden_q  <= rden_d;
      aen_q   <= aen_d;
      addr_q  <= addr_d;
      rg_d_q  <= reg_act ? efuse_rdata_i : '0;
      if (grant_go) begin
        lat_gnt  <= gnt;
        lat_wr   <= gnt_wr;
        lat_addr <= gnt_addr;
      end
      if (state == STROBE && tc && !lat_wr) begin
        rdata_q <= efuse_rdata_i;
      end
    end
  end

  assign busy          = (state != IDLE);
  assign bus.ack       = (state == DONE) ? lat_gnt : '0;
  assign bus.rdata     = rdata_q;
  assign rg_efuse_d    = rg_d_q;
  assign efuse_pgmen_o = pgmen_q && !scan_mode;
  assign efuse_rden_o  = rden_q && !scan_mode;
  assign efuse_aen_o   = aen_q && !scan_mode;
  assign efuse_addr_o  = scan_mode ? '0 : addr_q;

endmodule

// File: tb/tb_efuse_seq_arb.sv
// Directed bench for efuse_seq_arb: read/program timing, round-robin, register mode, scan, reset.
module tb_efuse_seq_arb;

  localparam int T_SETUP = 2;
  localparam int T_RD    = 4;
  localparam int T_PGM   = 16;
  localparam int T_HOLD  = 1;

  logic       clk;
  logic       rst_n;
  logic       scan_mode;
  logic       rg_efuse_reg_mode, rg_efuse_pgmen, rg_efuse_rden, rg_efuse_aen;
  logic [7:0] rg_efuse_addr;
  logic [7:0] rg_efuse_d;
  logic       busy, efuse_pgmen_o, efuse_rden_o, efuse_aen_o;
  logic [7:0] efuse_addr_o;
  logic [7:0] efuse_rdata_i;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] rdata_exp = 8'h00;
  int gap;
  int seen;
  logic [1:0] req_prev;

  efuse_seq_arb_if #(.NCH(2), .AW(8), .DW(8)) bus ();

  efuse_seq_arb #(
    .NCH(2), .AW(8), .DW(8),
    .T_SETUP(T_SETUP), .T_RD(T_RD), .T_PGM(T_PGM), .T_HOLD(T_HOLD)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .scan_mode         (scan_mode),
    .rg_efuse_reg_mode (rg_efuse_reg_mode),
    .rg_efuse_pgmen    (rg_efuse_pgmen),
    .rg_efuse_rden     (rg_efuse_rden),
    .rg_efuse_aen      (rg_efuse_aen),
    .rg_efuse_addr     (rg_efuse_addr),
    .rg_efuse_d        (rg_efuse_d),
    .bus               (bus),
    .busy              (busy),
    .efuse_pgmen_o     (efuse_pgmen_o),
    .efuse_rden_o      (efuse_rden_o),
    .efuse_aen_o       (efuse_aen_o),
    .efuse_addr_o      (efuse_addr_o),
    .efuse_rdata_i     (efuse_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A requester may only release its request once it has been acked.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(|(req_prev & ~bus.req & ~bus.ack)))
        else $error("illegal req drop prev=%b now=%b", req_prev, bus.req);
    end
    req_prev <= bus.req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic post(input int ch, input bit wr, input logic [7:0] addr);
    bus.req[ch]            = 1'b1;
    bus.req_wr[ch]         = wr;
    bus.req_addr[ch*8 +: 8] = addr;
  endtask

  // Follows one access from its first busy cycle (cycle 1) to the ack cycle.
  task automatic access(input int ch, input bit wr, input logic [7:0] addr, input logic [7:0] rd,
                        input int lat, input int aen_exp, input int stb_exp,
                        input int rm_at, input int scan_at, input bit chk_rd, output int wait_n);
    int n_aen, n_rd, n_pg, addr_bad, ack_k, last;
    logic [1:0] ack_v;
    n_aen = 0; n_rd = 0; n_pg = 0; addr_bad = 0; ack_k = 0; ack_v = 2'b00;
    last = T_SETUP + (wr ? T_PGM : T_RD);
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!busy && wait_n < 50);
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge clk);
      efuse_rdata_i = (k == last) ? rd : ~rd;
      if (k == rm_at) begin
        rg_efuse_reg_mode = 1'b1;
        rg_efuse_aen      = 1'b1;
        rg_efuse_addr     = 8'h55;
      end
      if (k == scan_at) begin
        scan_mode = 1'b1;
        #1;
        chk("scan_force", 32'({efuse_pgmen_o, efuse_rden_o, efuse_aen_o, efuse_addr_o}), 32'h0);
      end else begin
        #1;
      end
      if (efuse_aen_o)   n_aen++;
      if (efuse_rden_o)  n_rd++;
      if (efuse_pgmen_o) n_pg++;
      if (efuse_addr_o != (efuse_aen_o ? addr : 8'h00)) addr_bad++;
      if (bus.ack != 2'b00) begin
        ack_k   = k;
        ack_v   = bus.ack;
        bus.req = bus.req & ~bus.ack;
        break;
      end
    end
    if (ack_k == 0) bus.req[ch] = 1'b0;
    chk("ack_cycle", 32'(ack_k), 32'(lat));
    chk("ack_chan", 32'(ack_v), 32'(2'b01 << ch));
    chk("aen_cycles", 32'(n_aen), 32'(aen_exp));
    chk("rden_cycles", 32'(n_rd), wr ? 32'h0 : 32'(stb_exp));
    chk("pgmen_cycles", 32'(n_pg), wr ? 32'(stb_exp) : 32'h0);
    chk("addr_bad_cycles", 32'(addr_bad), 32'h0);
    if (chk_rd) begin
      if (!wr) rdata_exp = rd;
      chk("rdata", 32'(bus.rdata), 32'(rdata_exp));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; scan_mode = 1'b0;
    rg_efuse_reg_mode = 1'b0; rg_efuse_pgmen = 1'b0; rg_efuse_rden = 1'b0; rg_efuse_aen = 1'b0;
    rg_efuse_addr = 8'h00; efuse_rdata_i = 8'h00;
    bus.req = 2'b00; bus.req_wr = 2'b00; bus.req_addr = 16'h0000;
    #12;
    chk("rst_pins", 32'({efuse_pgmen_o, efuse_rden_o, efuse_aen_o, efuse_addr_o}), 32'h0);
    chk("rst_busy_ack", 32'({busy, bus.ack}), 32'h0);
    chk("rst_rdata", 32'({bus.rdata, rg_efuse_d}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // read ch0, then program ch1
    post(0, 1'b0, 8'h3C);
    access(0, 1'b0, 8'h3C, 8'hA5, 8, 7, 4, 0, 0, 1'b1, gap);
    post(1, 1'b1, 8'h10);
    access(1, 1'b1, 8'h10, 8'hEE, 20, 19, 16, 0, 0, 1'b1, gap);

    // simultaneous pair from pointer at ch0
    post(0, 1'b0, 8'h21);
    post(1, 1'b0, 8'h42);
    access(0, 1'b0, 8'h21, 8'h11, 8, 7, 4, 0, 0, 1'b1, gap);
    access(1, 1'b0, 8'h42, 8'h22, 8, 7, 4, 0, 0, 1'b1, gap);
    chk("rr_gap", 32'(gap), 32'd2);

    // ch0 alone moves the pointer to ch1, so the next pair starts at ch1
    post(0, 1'b0, 8'h05);
    access(0, 1'b0, 8'h05, 8'h33, 8, 7, 4, 0, 0, 1'b1, gap);
    post(0, 1'b0, 8'h21);
    post(1, 1'b0, 8'h42);
    access(1, 1'b0, 8'h42, 8'h44, 8, 7, 4, 0, 0, 1'b1, gap);
    access(0, 1'b0, 8'h21, 8'h55, 8, 7, 4, 0, 0, 1'b1, gap);

    // register mode in IDLE with a pending request
    @(negedge clk);
    rg_efuse_reg_mode = 1'b1; rg_efuse_rden = 1'b1; rg_efuse_aen = 1'b1; rg_efuse_addr = 8'h7F;
    efuse_rdata_i = 8'h5A;
    post(0, 1'b0, 8'h3C);
    #1;
    chk("rm_delay", 32'(efuse_rden_o), 32'h0);
    @(negedge clk);
    chk("rm_pins", 32'({efuse_pgmen_o, efuse_rden_o, efuse_aen_o, efuse_addr_o}), 32'h37F);
    chk("rm_d", 32'(rg_efuse_d), 32'h5A);
    efuse_rdata_i = 8'hC3; rg_efuse_rden = 1'b0; rg_efuse_pgmen = 1'b1;
    @(negedge clk);
    chk("rm_pins2", 32'({efuse_pgmen_o, efuse_rden_o, efuse_aen_o, efuse_addr_o}), 32'h57F);
    chk("rm_d2", 32'(rg_efuse_d), 32'hC3);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || bus.ack != 2'b00) seen++;
    end
    chk("rm_no_grant", 32'(seen), 32'h0);
    rg_efuse_reg_mode = 1'b0; rg_efuse_pgmen = 1'b0; rg_efuse_aen = 1'b0; rg_efuse_addr = 8'h00;
    access(0, 1'b0, 8'h3C, 8'h66, 8, 7, 4, 0, 0, 1'b1, gap);
    chk("rg_d_off", 32'(rg_efuse_d), 32'h0);

    // register mode raised mid-program must not truncate it
    post(1, 1'b1, 8'h10);
    access(1, 1'b1, 8'h10, 8'h99, 20, 19, 16, 5, 0, 1'b1, gap);
    @(negedge clk);
    chk("rm_idle_first", 32'({busy, efuse_aen_o, efuse_addr_o}), 32'h0);
    @(negedge clk);
    chk("rm_override", 32'({efuse_aen_o, efuse_addr_o}), 32'h155);
    rg_efuse_reg_mode = 1'b0; rg_efuse_aen = 1'b0; rg_efuse_addr = 8'h00;
    @(negedge clk);

    // scan during a read: pins forced low, ack still delivered, new grant held off
    post(0, 1'b0, 8'h2A);
    access(0, 1'b0, 8'h2A, 8'h99, 8, 2, 0, 0, 3, 1'b0, gap);
    post(1, 1'b0, 8'h42);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) seen++;
    end
    chk("scan_hold", 32'(seen), 32'h0);
    scan_mode = 1'b0;
    access(1, 1'b0, 8'h42, 8'h77, 8, 7, 4, 0, 0, 1'b1, gap);

    // async reset mid-strobe
    @(negedge clk);
    post(0, 1'b0, 8'h3C);
    @(negedge clk);
    chk("rst_seq_busy", 32'(busy), 32'h1);
    repeat (3) @(negedge clk);
    chk("rst_seq_rden", 32'(efuse_rden_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_pins", 32'({efuse_pgmen_o, efuse_rden_o, efuse_aen_o, efuse_addr_o}), 32'h0);
    chk("rst_async_state", 32'({busy, bus.rdata}), 32'h0);
    bus.req = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.ack != 2'b00 || busy) seen++;
    end
    chk("rst_no_ack", 32'(seen), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
